// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    localparam int BCD_DIGIT_W = 4;

    // Decimal digits needed to represent 2^n - 1.
    function automatic int bcd_digits_for(input int n);
        longint unsigned max_v;
        longint unsigned p;
        int d;
        max_v = (64'd1 << n) - 64'd1;
        p = 64'd10;
        d = 1;
        while (p <= max_v) begin
            d = d + 1;
            p = p * 64'd10;
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to any BCD digit of 5 or more.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock,
// with valid/ready handshakes on both sides.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int N      = 8,
    parameter int DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N-1:0]                  in_bin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd
);

    localparam int CW = $clog2(N + 1);
    localparam int BW = BCD_DIGIT_W * DIGITS;

    if (DIGITS < bcd_digits_for(N)) begin : g_bad_digits
        $error("bin2bcd_seq: DIGITS too small to hold 2^N-1");
    end

    state_e         state_q, state_d;
    logic [N-1:0]   bin_q, bin_d;
    logic [BW-1:0]  acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [BW-1:0]  bcd_q, bcd_d;
    logic [BW-1:0]  acc_adj;
    logic [BW+N-1:0] shifted;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (acc_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .dout (acc_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign shifted = {acc_adj, bin_q} << 1;

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bin_d   = in_bin;
                    acc_d   = '0;
                    cnt_d   = CW'(N);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d = shifted[BW+N-1:N];
                bin_d = shifted[N-1:0];
                cnt_d = cnt_q - CW'(1);
                // Last bit: the fresh accumulator is the final result.
                if (cnt_q == CW'(1)) begin
                    bcd_d   = shifted[BW+N-1:N];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_bcd   = bcd_q;

endmodule
